sr_serial_tx: RTL
=================

Name: sr_serial_tx

Overview:
Serial transmitter that feeds a downstream parallel-load shift register through its serial inputs. It accepts a W-bit word on a valid/ready handshake and emits the word one bit per clock, MSB-first on sl_out or LSB-first on sr_out. It also drives the matching 3-bit mode code for the shift register's S input, so a receiving shift register reconstructs the word after W shifts.

Parameters:
W, 8, word width in bits (W >= 2).
CW, 4, bit-counter width; must satisfy 2^CW > W.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
din  input  W  parallel word to transmit
dir  input  1  direction, sampled with din: 0 = MSB-first on sl_out (shift-left), 1 = LSB-first on sr_out (shift-right)
load_valid  input  1  din/dir valid
load_ready  output  1  block can accept a word
abort  input  1  synchronous cancel of the transfer in progress
sl_out  output  1  serial bit for the downstream shift-left input
sr_out  output  1  serial bit for the downstream shift-right input
mode  output  3  downstream S code: 000 hold, 001 parallel load (never driven by this block), 010 shift-left, 011 shift-right
busy  output  1  high while bits are being emitted
done  output  1  one-cycle pulse after the last bit

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All outputs are registered except load_ready, which is decoded from state.
- Reset values:
  - state = IDLE
  - sl_out = 0, sr_out = 0
  - mode = 000
  - busy = 0, done = 0
  - load_ready = 1 (first cycle after reset)
  - internal shift register and bit counter = 0
- States: IDLE, SHIFT, DONE.
- IDLE:
  - load_ready = 1.
  - On an edge with load_valid = 1: latch din into shreg, latch dir, set cnt = W, go to SHIFT.
  - Emit the first bit on the same edge: dir = 0 gives sl_out = din[W-1]; dir = 1 gives sr_out = din[0].
  - mode = 010 or 011 according to dir; busy = 1.
- SHIFT:
  - load_ready = 0; load_valid is ignored.
  - Each edge: decrement cnt and emit the next bit.
    - dir = 0: shreg shifts left and sl_out takes the next-MSB bit.
    - dir = 1: shreg shifts right and sr_out takes the next-LSB bit.
  - The unused serial output is held at 0.
  - When the edge would drop cnt to 0, the last bit has already been shown for one cycle. On that edge go to DONE with done = 1, busy = 0, mode = 000, sl_out = sr_out = 0.
- Timing:
  - Bit i (i = 0..W-1) is visible during cycle k+1+i after an accept edge k.
  - done is high during cycle k+W+1.
- DONE:
  - Lasts exactly one cycle, then IDLE. done returns to 0.
  - load_ready = 0 in DONE, so the earliest next accept is at the end of cycle k+W+2. There is no back-to-back overlap.
- abort:
  - Takes effect at the next edge in SHIFT or DONE.
  - Forces IDLE, all outputs to reset values, no done pulse.
  - In IDLE, abort has priority over load_valid: no accept.
- Priority: rst > abort > load handshake.
- A reset in mid-transfer discards the word; no done is produced.
- din and dir are sampled only at the accept edge. Later changes have no effect on the word in flight.
- Downstream contract: a receiving shift register clocked on clk with S = mode holds exactly din after the W-th shift. The emitted bit is presented in the cycle in which mode commands that shift.

Test Plan:
- Reset: hold rst for 2 cycles with load_valid = 1 → load_ready = 1, busy = 0, done = 0, mode = 000, sl_out = sr_out = 0; no accept while rst is high.
- MSB-first: din = 8'd58 (0011_1010), dir = 0, accept at edge k → sl_out = 0,0,1,1,1,0,1,0 in cycles k+1..k+8; mode = 010; sr_out = 0; done = 1 only in cycle k+9; load_ready = 1 from cycle k+10.
- LSB-first: din = 8'd58, dir = 1 → sr_out = 0,1,0,1,1,1,0,0 in cycles k+1..k+8; mode = 011; sl_out = 0.
- Loopback: connect the outputs to a behavioural 8-bit shift register with S = mode, for din = 8'hA5 and both dir values → register equals 8'hA5 when done = 1.
- Abort: assert abort in cycle k+4 of a transfer → IDLE at the next edge, no done pulse, load_ready = 1; a following word 8'hFF transmits correctly.
- Handshake: hold load_valid = 1 with din changing during SHIFT → only the word present at the accept edge is sent; the second accept happens no earlier than edge k+10.

Source files
------------

// File: rtl/sr_serial_tx.sv
// Serial transmitter feeding a downstream parallel-load shift register.
// Accepts a word on valid/ready and emits it MSB-first on sl_out or LSB-first on sr_out.
module sr_serial_tx #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         dir,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic         abort,
    output logic         sl_out,
    output logic         sr_out,
    output logic [2:0]   mode,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [2:0]    MODE_HOLD = 3'b000;
    localparam logic [2:0]    MODE_SL   = 3'b010;
    localparam logic [2:0]    MODE_SR   = 3'b011;
    localparam logic [CW-1:0] CNT_INIT  = CW'(W);

    state_t        state;
    logic [W-1:0]  shreg;
    logic [CW-1:0] cnt;
    logic          dir_q;

    assign load_ready = (state == IDLE);

    // abort is harmless in IDLE (everything is already at rest) and must block an accept there
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            dir_q  <= 1'b0;
            sl_out <= 1'b0;
            sr_out <= 1'b0;
            mode   <= MODE_HOLD;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (load_valid) begin
                        state  <= SHIFT;
                        shreg  <= din;
                        dir_q  <= dir;
                        cnt    <= CNT_INIT;
                        busy   <= 1'b1;
                        mode   <= dir ? MODE_SR : MODE_SL;
                        sl_out <= ~dir & din[W-1];
                        sr_out <= dir & din[0];
                    end
                end

                // The last bit has been on the wire for a full cycle when cnt reaches 1
                SHIFT: begin
                    if (cnt == {{(CW-1){1'b0}}, 1'b1}) begin
                        state  <= DONE;
                        cnt    <= '0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        mode   <= MODE_HOLD;
                        sl_out <= 1'b0;
                        sr_out <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (dir_q) begin
                            shreg  <= shreg >> 1;
                            sr_out <= shreg[1];
                            sl_out <= 1'b0;
                        end else begin
                            shreg  <= shreg << 1;
                            sl_out <= shreg[W-2];
                            sr_out <= 1'b0;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
